// File: rtl/bus_ctrl_pkg.sv
// bus_ctrl_pkg: shared FSM state type and index helpers for bus_xfer_ctrl.
//   state_t    : IDLE/DRIVE/LOAD/TURN transfer sequencer states
//   idx_w()    : index width for n items (never below 1)
//   onehot_bit(): bit i of the one-hot decode of idx
package bus_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, DRIVE, LOAD, TURN} state_t;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic logic onehot_bit(input int idx, input int i);
    return idx == i;
  endfunction
endpackage

// File: rtl/bus_xfer_ctrl_arb.sv
// rr_arbiter: combinational round-robin pick among NUM_REQ requesters.
//   req   in  NUM_REQ  level requests
//   ptr   in  PW       requester that has highest priority this cycle
//   win   out NUM_REQ  one-hot winner (zero when no request)
//   valid out 1        some requester won
module rr_arbiter import bus_ctrl_pkg::*; #(
  parameter int NUM_REQ = 2,
  localparam int PW = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PW-1:0]      ptr,
  output logic [NUM_REQ-1:0] win,
  output logic               valid
);
  always_comb begin
    win = '0;
    valid = 1'b0;
    for (int i = 0; i < NUM_REQ; i++)
      for (int j = 0; j < NUM_REQ; j++)
        if (!valid && req[j] && j == (int'(ptr) + i) % NUM_REQ) begin
          win[j] = 1'b1;
          valid = 1'b1;
        end
  end
endmodule

// File: rtl/bus_xfer_ctrl.sv
// bus_xfer_ctrl: sequences register-to-register moves over a shared tri-state bus.
//   clk, reset (async, active-high)
//   req/src_idx/dst_idx in : per-requester level request and packed indices
//   grant   out : one-hot pulse, request accepted and indices latched
//   out_en  out : one-hot/zero bus register output enables
//   load    out : one-hot/zero bus register load strobes
//   done    out : pulse in the cycle after the destination captured
//   fault   out : only with XFER_FAULT_EN; pulses instead of done for src==dst or
//                 out-of-range index, and such a transfer drives/loads nothing
//   busy    out : sequencer not idle
module bus_xfer_ctrl import bus_ctrl_pkg::*; #(
  parameter int NUM_REGS = 8,
  parameter int NUM_REQ = 2,
  localparam int IDX_W = idx_w(NUM_REGS),
  localparam int PW = idx_w(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*IDX_W-1:0] src_idx,
  input  logic [NUM_REQ*IDX_W-1:0] dst_idx,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REGS-1:0]      out_en,
  output logic [NUM_REGS-1:0]      load,
  output logic                     done,
`ifdef XFER_FAULT_EN
  output logic                     fault,
`endif
  output logic                     busy
);
  state_t state_q, state_d;
  logic [IDX_W-1:0] src_q, src_d, dst_q, dst_d, win_src, win_dst;
  logic [PW-1:0] ptr_q, ptr_d, win_ptr;
  logic [NUM_REQ-1:0] win, grant_q, grant_d;
  logic [NUM_REGS-1:0] out_en_q, out_en_d, load_q, load_d, src_oh, dst_oh;
  logic win_v, arb, bad, done_q, done_d, busy_q, busy_d, fault_q, fault_d;
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (.req(req), .ptr(ptr_q), .win(win), .valid(win_v));
  always_comb begin
    win_src = '0;
    win_dst = '0;
    win_ptr = '0;
    for (int r = 0; r < NUM_REQ; r++)
      if (win[r]) begin
        win_src = src_idx[r*IDX_W +: IDX_W];
        win_dst = dst_idx[r*IDX_W +: IDX_W];
        win_ptr = PW'((r + 1) % NUM_REQ);
      end
  end
  // Outputs are computed from the next state so every strobe comes straight off a flop.
  always_comb begin
    arb = (state_q == IDLE || state_q == TURN) && win_v;
    state_d = arb ? DRIVE : state_q == DRIVE ? LOAD : state_q == LOAD ? TURN : IDLE;
    grant_d = arb ? win : '0;
    src_d = arb ? win_src : src_q;
    dst_d = arb ? win_dst : dst_q;
    ptr_d = arb ? win_ptr : ptr_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      src_oh[i] = onehot_bit(int'(src_d), i);
      dst_oh[i] = onehot_bit(int'(dst_d), i);
    end
`ifdef XFER_FAULT_EN
    bad = src_d == dst_d || int'(src_d) >= NUM_REGS || int'(dst_d) >= NUM_REGS;
`else
    bad = 1'b0;
`endif
    out_en_d = (state_d == DRIVE || state_d == LOAD) && !bad ? src_oh : '0;
    load_d = state_d == LOAD && !bad ? dst_oh : '0;
    done_d = state_d == TURN && !bad;
    fault_d = state_d == TURN && bad;
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      src_q <= '0;
      dst_q <= '0;
      ptr_q <= '0;
      grant_q <= '0;
      out_en_q <= '0;
      load_q <= '0;
      done_q <= 1'b0;
      fault_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q <= src_d;
      dst_q <= dst_d;
      ptr_q <= ptr_d;
      grant_q <= grant_d;
      out_en_q <= out_en_d;
      load_q <= load_d;
      done_q <= done_d;
      fault_q <= fault_d;
      busy_q <= busy_d;
    end
  assign grant = grant_q;
  assign out_en = out_en_q;
  assign load = load_q;
  assign done = done_q;
  assign busy = busy_q;
`ifdef XFER_FAULT_EN
  assign fault = fault_q;
`else
  logic unused_fault;
  assign unused_fault = fault_q;
`endif
endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// tb_bus_xfer_ctrl: scoreboard bench for bus_xfer_ctrl with an 8-register bus model.
module tb_bus_xfer_ctrl;
  localparam int NR = 8, NQ = 2, IW = 3;
  logic clk = 1'b0, reset = 1'b1;
  logic [NQ-1:0] req = '0;
  logic [NQ*IW-1:0] src_idx = '0, dst_idx = '0;
  logic [NQ-1:0] grant;
  logic [NR-1:0] out_en, load;
  logic done, busy;
`ifdef XFER_FAULT_EN
  logic fault;
`endif
  int checks = 0, errors = 0, cyc = 0, exp_ptr = 0, ph = 0;
  bit mon_on = 1'b0;
  typedef struct {logic [NQ-1:0] g; logic [NR-1:0] oe, ld; logic dn, ft;} exp_t;
  exp_t q[$];
  exp_t cur;
  logic [31:0] regs [NR];
  logic [31:0] bus_val;

  bus_xfer_ctrl #(.NUM_REGS(NR), .NUM_REQ(NQ)) dut (
    .clk(clk), .reset(reset), .req(req), .src_idx(src_idx), .dst_idx(dst_idx),
    .grant(grant), .out_en(out_en), .load(load), .done(done),
`ifdef XFER_FAULT_EN
    .fault(fault),
`endif
    .busy(busy));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always_comb begin
    bus_val = '0;
    for (int i = 0; i < NR; i++) if (out_en[i]) bus_val |= regs[i];
  end
  always @(posedge clk) if (!reset) for (int i = 0; i < NR; i++) if (load[i]) regs[i] <= bus_val;

  function automatic exp_t mk(input int w, input int s, input int d);
    exp_t e;
    logic bad;
`ifdef XFER_FAULT_EN
    bad = (s == d) || s >= NR || d >= NR;
`else
    bad = 1'b0;
`endif
    e.g = NQ'(1) << w;
    e.oe = bad ? '0 : NR'(1) << s;
    e.ld = bad ? '0 : NR'(1) << d;
    e.dn = !bad;
    e.ft = bad;
    return e;
  endfunction

  // Scoreboard monitor: each grant pops the next expected transfer and follows it
  // through DRIVE, LOAD and TURN.
  always @(negedge clk) if (mon_on) begin
    checks++;
    if ($countones(out_en) > 1 || $countones(load) > 1) begin
      errors++;
      $display("FAIL contention out_en=%h load=%h", out_en, load);
    end
    if (ph == 0) begin
      checks++;
      if (grant != '0) begin
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_grant got=%b exp=00", grant);
        end else begin
          cur = q.pop_front();
          if (grant !== cur.g || out_en !== cur.oe || load !== '0) begin
            errors++;
            $display("FAIL drive_phase grant=%b out_en=%h load=%h exp grant=%b out_en=%h load=00",
                     grant, out_en, load, cur.g, cur.oe);
          end
          ph = 1;
        end
      end else if (done !== 1'b0 || out_en !== '0 || load !== '0) begin
        errors++;
        $display("FAIL idle_outputs done=%b out_en=%h load=%h exp 0", done, out_en, load);
      end
    end else if (ph == 1) begin
      checks++;
      if (out_en !== cur.oe || load !== cur.ld || grant !== '0) begin
        errors++;
        $display("FAIL load_phase out_en=%h load=%h grant=%b exp out_en=%h load=%h grant=00",
                 out_en, load, grant, cur.oe, cur.ld);
      end
      ph = 2;
    end else begin
      checks++;
      if (done !== cur.dn || out_en !== '0 || load !== '0) begin
        errors++;
        $display("FAIL turn_phase done=%b out_en=%h load=%h exp done=%b out_en=00 load=00",
                 done, out_en, load, cur.dn);
      end
`ifdef XFER_FAULT_EN
      checks++;
      if (fault !== cur.ft) begin
        errors++;
        $display("FAIL turn_fault got=%b exp=%b", fault, cur.ft);
      end
`endif
      ph = 0;
    end
  end

  task automatic set_idx(input int r, input int s, input int d);
    src_idx[r*IW +: IW] = IW'(s);
    dst_idx[r*IW +: IW] = IW'(d);
  endtask

  task automatic wait_idle(input string nm);
    bit ok = 1'b0;
    for (int t = 0; t < 60 && !ok; t++) begin
      @(negedge clk);
      #1;
      ok = ph == 0 && q.size() == 0 && busy === 1'b0;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_idle_timeout ph=%0d pending=%0d busy=%b exp idle", nm, ph, q.size(), busy);
    end
  endtask

  task automatic run_one(input int s, input int d);
    bit got = 1'b0;
    set_idx(0, s, d);
    q.push_back(mk(0, s, d));
    exp_ptr = 1;
    @(negedge clk);
    req = 2'b01;
    for (int t = 0; t < 10 && !got; t++) begin
      @(negedge clk);
      got = grant != '0;
    end
    req = '0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL grant_timeout src=%0d dst=%0d got=none exp=01", s, d);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    @(negedge clk);
    checks += 5;
    if (grant !== '0) begin errors++; $display("FAIL reset_grant got=%b exp=00", grant); end
    if (out_en !== '0) begin errors++; $display("FAIL reset_out_en got=%h exp=00", out_en); end
    if (load !== '0) begin errors++; $display("FAIL reset_load got=%h exp=00", load); end
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    reset = 1'b0;
    exp_ptr = 0;
    mon_on = 1'b1;
  endtask

  task automatic test_single;
    set_idx(0, 2, 5);
    q.push_back(mk(0, 2, 5));
    exp_ptr = 1;
    @(negedge clk);
    req = 2'b01;
    @(negedge clk);
    checks++;
    if (grant !== 2'b01 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_latency grant=%b busy=%b exp grant=01 busy=1", grant, busy);
    end
    req = '0;
    wait_idle("single");
  endtask

  task automatic test_round_robin;
    int cnt = 0, last_w = 0, last_cyc = 0;
    set_idx(0, 1, 2);
    set_idx(1, 3, 4);
    for (int n = 0; n < 4; n++) begin
      last_w = (exp_ptr + n) % NQ;
      q.push_back(last_w == 1 ? mk(1, 3, 4) : mk(0, 1, 2));
    end
    exp_ptr = (last_w + 1) % NQ;
    @(negedge clk);
    req = 2'b11;
    for (int t = 0; t < 40 && cnt < 4; t++) begin
      @(negedge clk);
      if (grant != '0) begin
        if (cnt > 0) begin
          checks++;
          if (cyc - last_cyc != 3) begin
            errors++;
            $display("FAIL rr_spacing got=%0d exp=3", cyc - last_cyc);
          end
        end
        last_cyc = cyc;
        cnt++;
        if (cnt == 4) req = '0;
      end
    end
    req = '0;
    checks++;
    if (cnt != 4) begin
      errors++;
      $display("FAIL rr_grant_count got=%0d exp=4", cnt);
    end
    wait_idle("rr");
  endtask

  task automatic test_bus_move;
    regs[3] = 32'hDEAD_BEEF;
    run_one(3, 6);
    wait_idle("bus");
    checks++;
    if (regs[6] !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL bus_move_r6 got=%h exp=deadbeef", regs[6]);
    end
  endtask

  task automatic test_self_move;
    run_one(4, 4);
    wait_idle("self");
  endtask

  task automatic test_drop;
    int extra = 0;
    set_idx(1, 5, 0);
    run_one(0, 1);
    req = 2'b10;
    @(negedge clk);
    req = '0;
    wait_idle("drop");
    repeat (6) begin
      @(negedge clk);
      if (grant != '0) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL drop_extra_grants got=%0d exp=0", extra);
    end
  endtask

  task automatic test_reset_mid;
    mon_on = 1'b0;
    set_idx(0, 1, 2);
    @(negedge clk);
    req = 2'b01;
    @(negedge clk);
    req = '0;
    checks++;
    if (grant !== 2'b01) begin errors++; $display("FAIL mid_grant got=%b exp=01", grant); end
    @(negedge clk);
    checks++;
    if (out_en !== 8'h02 || load !== 8'h04) begin
      errors++;
      $display("FAIL mid_load_phase out_en=%h load=%h exp out_en=02 load=04", out_en, load);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (out_en !== '0 || load !== '0 || busy !== 1'b0 || grant !== '0) begin
      errors++;
      $display("FAIL mid_async_clear out_en=%h load=%h busy=%b grant=%b exp 0", out_en, load, busy, grant);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL mid_done_in_reset got=%b exp=0", done); end
    reset = 1'b0;
    q.delete();
    ph = 0;
    exp_ptr = 0;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || out_en !== '0) begin
        errors++;
        $display("FAIL mid_after_release busy=%b done=%b out_en=%h exp 0", busy, done, out_en);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < NR; i++) regs[i] = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_bus_move();
    test_self_move();
    test_drop();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
